// File: rtl/agc_peak_ctrl.sv
// agc_peak_ctrl: windowed peak detector driving a stepped gain index with hysteresis, confirmation and clip attack
module agc_peak_ctrl #(
    parameter int DATA_W     = 12,
    parameter int NUM_GAINS  = 4,
    parameter int GAIN_W     = 2,
    parameter int RESET_GAIN = 3,
    parameter int WIN_LEN    = 256,
    parameter int SETTLE_CYC = 16,
    parameter int CONFIRM    = 2,
    parameter int TH_HIGH    = 3686,
    parameter int TH_LOW     = 1792
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [GAIN_W-1:0] gain_idx,
    output logic              gain_chg,
    output logic              stable,
    output logic [DATA_W-1:0] peak_out,
    output logic              peak_valid,
    output logic              range_err
);
    localparam int WC_W = $clog2(WIN_LEN);
    localparam int CF_W = $clog2(CONFIRM + 1);
    localparam int SC_W = $clog2(SETTLE_CYC + 1);
    localparam logic [WC_W-1:0]   WIN_LAST    = WC_W'(WIN_LEN - 1);
    localparam logic [CF_W-1:0]   CONF_N      = CF_W'(CONFIRM);
    localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
    localparam logic [GAIN_W-1:0] GAIN_MAX    = GAIN_W'(NUM_GAINS - 1);
    localparam logic [GAIN_W-1:0] GAIN_RST    = GAIN_W'(RESET_GAIN);
    localparam logic [DATA_W-1:0] HI          = DATA_W'(TH_HIGH);
    localparam logic [DATA_W-1:0] LO          = DATA_W'(TH_LOW);
    typedef enum logic {MEASURE, SETTLE} state_t;
    state_t            state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              gain_chg_q, gain_chg_d, stable_q, stable_d;
    logic              peak_valid_q, peak_valid_d, range_err_q, range_err_d;
    logic [DATA_W-1:0] peak_q, peak_d, run_peak_q, run_peak_d, new_peak;
    logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CF_W-1:0]   over_q, over_d, under_q, under_d, over_n, under_n;
    logic [SC_W-1:0]   settle_q, settle_d;
    logic              acc, clip, win_end, dn_req, up_req, at_limit;
    always_comb begin
        acc          = enable && state_q == MEASURE && sample_valid;
        clip         = acc && &sample_data;
        win_end      = acc && win_cnt_q == WIN_LAST;
        new_peak     = sample_data > run_peak_q ? sample_data : run_peak_q;
        over_n       = new_peak >= HI ? (over_q == CONF_N ? over_q : over_q + CF_W'(1)) : '0;
        under_n      = new_peak < LO ? (under_q == CONF_N ? under_q : under_q + CF_W'(1)) : '0;
        dn_req       = clip || (win_end && over_n == CONF_N);
        up_req       = !clip && win_end && under_n == CONF_N;
        at_limit     = dn_req ? gain_q == '0 : gain_q == GAIN_MAX;
        state_d      = state_q;
        gain_d       = gain_q;
        gain_chg_d   = 1'b0;
        stable_d     = stable_q;
        peak_d       = peak_q;
        peak_valid_d = 1'b0;
        range_err_d  = 1'b0;
        run_peak_d   = run_peak_q;
        win_cnt_d    = win_cnt_q;
        over_d       = over_q;
        under_d      = under_q;
        settle_d     = settle_q;
        if (!enable) begin
            state_d    = MEASURE;
            stable_d   = 1'b0;
            run_peak_d = '0;
            win_cnt_d  = '0;
            over_d     = '0;
            under_d    = '0;
            settle_d   = '0;
        end else if (state_q == SETTLE) begin
            settle_d = settle_q == SETTLE_LAST ? '0 : settle_q + SC_W'(1);
            state_d  = settle_q == SETTLE_LAST ? MEASURE : SETTLE;
        end else if (acc) begin
            run_peak_d = win_end || clip ? '0 : new_peak;
            win_cnt_d  = win_end || clip ? '0 : win_cnt_q + WC_W'(1);
            if (win_end && !clip) begin
                peak_d       = new_peak;
                peak_valid_d = 1'b1;
                stable_d     = 1'b1;
                over_d       = over_n;
                under_d      = under_n;
            end
            if (dn_req || up_req) begin
                over_d  = '0;
                under_d = '0;
                if (at_limit) begin
                    range_err_d = 1'b1;
                end else begin
                    gain_d     = dn_req ? gain_q - GAIN_W'(1) : gain_q + GAIN_W'(1);
                    gain_chg_d = 1'b1;
                    stable_d   = 1'b0;
                    state_d    = SETTLE;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= MEASURE;
            gain_q       <= GAIN_RST;
            gain_chg_q   <= 1'b0;
            stable_q     <= 1'b0;
            peak_q       <= '0;
            peak_valid_q <= 1'b0;
            range_err_q  <= 1'b0;
            run_peak_q   <= '0;
            win_cnt_q    <= '0;
            over_q       <= '0;
            under_q      <= '0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            gain_chg_q   <= gain_chg_d;
            stable_q     <= stable_d;
            peak_q       <= peak_d;
            peak_valid_q <= peak_valid_d;
            range_err_q  <= range_err_d;
            run_peak_q   <= run_peak_d;
            win_cnt_q    <= win_cnt_d;
            over_q       <= over_d;
            under_q      <= under_d;
            settle_q     <= settle_d;
        end
    end
    assign gain_idx   = gain_q;
    assign gain_chg   = gain_chg_q;
    assign stable     = stable_q;
    assign peak_out   = peak_q;
    assign peak_valid = peak_valid_q;
    assign range_err  = range_err_q;
endmodule

// File: tb/tb_agc_peak_ctrl.sv
// tb_agc_peak_ctrl: table vectors, directed corner sequences and random traffic against a queue-based window model
module tb_agc_peak_ctrl;
    localparam int WIN = 8, SET = 4, CONF = 2, TH_H = 3686, TH_L = 1792, GMAX = 3, CLIP = 4095;
    logic        clk = 1'b0, rst_n, enable, sample_valid;
    logic [11:0] sample_data, peak_out;
    logic [1:0]  gain_idx;
    logic        gain_chg, stable, peak_valid, range_err;
    agc_peak_ctrl #(.WIN_LEN(WIN), .SETTLE_CYC(SET), .CONFIRM(CONF)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
        .sample_data(sample_data), .gain_idx(gain_idx), .gain_chg(gain_chg), .stable(stable),
        .peak_out(peak_out), .peak_valid(peak_valid), .range_err(range_err)
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0;
    int m_gain, m_peak, m_settle, m_over, m_under;
    bit m_stable, m_chg, m_pv, m_re;
    int win[$];
    typedef struct {
        bit en; bit v; int d; int gain; bit chg; bit stb; bit pv; int peak;
    } vec_t;
    vec_t tbl[$];
    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic void m_req(input int dir);
        m_over  = 0;
        m_under = 0;
        if (m_gain + dir < 0 || m_gain + dir > GMAX) m_re = 1;
        else begin
            m_gain  += dir;
            m_chg    = 1;
            m_stable = 0;
            m_settle = SET;
        end
    endfunction
    function automatic void model_step(input bit r, input bit en, input bit v, input int d);
        int pk;
        m_chg = 0; m_pv = 0; m_re = 0;
        if (!r) begin
            m_gain = GMAX; m_peak = 0; m_stable = 0; m_settle = 0; m_over = 0; m_under = 0;
            win.delete();
        end else if (!en) begin
            m_stable = 0; m_settle = 0; m_over = 0; m_under = 0;
            win.delete();
        end else if (m_settle > 0) begin
            m_settle--;
        end else if (v && d == CLIP) begin
            win.delete();
            m_req(-1);
        end else if (v) begin
            win.push_back(d);
            if (win.size() == WIN) begin
                pk = 0;
                foreach (win[i]) if (win[i] > pk) pk = win[i];
                win.delete();
                m_peak = pk; m_pv = 1; m_stable = 1;
                m_over  = pk >= TH_H ? (m_over < CONF ? m_over + 1 : CONF) : 0;
                m_under = pk < TH_L ? m_under + 1 : 0;
                if (m_over == CONF) m_req(-1);
                else if (m_under == CONF) m_req(1);
            end
        end
    endfunction
    task automatic cycle(input bit r, input bit en, input bit v, input int d);
        rst_n = r; enable = en; sample_valid = v; sample_data = 12'(d);
        @(posedge clk);
        #1;
        model_step(r, en, v, d);
        chk("gain_idx", 32'(gain_idx), m_gain);
        chk("gain_chg", 32'(gain_chg), int'(m_chg));
        chk("stable", 32'(stable), int'(m_stable));
        chk("peak_valid", 32'(peak_valid), int'(m_pv));
        chk("peak_out", 32'(peak_out), m_peak);
        chk("range_err", 32'(range_err), int'(m_re));
    endtask
    task automatic win8(input int pk, input int rest);
        cycle(1, 1, 1, pk);
        for (int i = 1; i < WIN; i++) cycle(1, 1, 1, rest);
    endtask
    task automatic settle();
        for (int i = 0; i < SET; i++) cycle(1, 1, 0, 0);
    endtask
    function automatic void add(input bit en, input bit v, input int d, input int g,
                                input bit c, input bit s, input bit p, input int pk);
        tbl.push_back('{en, v, d, g, c, s, p, pk});
    endfunction
    initial begin
        int mode = 0, d;
        bit r, en, v;
        rst_n = 0; enable = 0; sample_valid = 0; sample_data = 0;
        for (int i = 0; i < 7; i++) add(1, 1, 2500, 3, 0, 0, 0, 0);
        add(1, 1, 2500, 3, 0, 1, 1, 2500);
        add(1, 0, 0, 3, 0, 1, 0, 2500);
        add(1, 1, 3800, 3, 0, 1, 0, 2500);
        for (int i = 0; i < 6; i++) add(1, 1, 100, 3, 0, 1, 0, 2500);
        add(1, 1, 100, 3, 0, 1, 1, 3800);
        add(1, 1, 3800, 3, 0, 1, 0, 3800);
        for (int i = 0; i < 6; i++) add(1, 1, 100, 3, 0, 1, 0, 3800);
        add(1, 1, 100, 2, 1, 0, 1, 3800);
        for (int i = 0; i < SET; i++) add(1, 1, 4000, 2, 0, 0, 0, 3800);
        for (int i = 0; i < 7; i++) add(1, 1, 2000, 2, 0, 0, 0, 3800);
        add(1, 1, 2000, 2, 0, 1, 1, 2000);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 100);
        chk("rst_gain", 32'(gain_idx), 3);
        chk("rst_stable", 32'(stable), 0);
        chk("rst_peak", 32'(peak_out), 0);
        chk("rst_pulses", {29'd0, gain_chg, peak_valid, range_err}, 0);
        foreach (tbl[i]) begin
            cycle(1, tbl[i].en, tbl[i].v, tbl[i].d);
            chk("tbl_gain", 32'(gain_idx), tbl[i].gain);
            chk("tbl_chg", 32'(gain_chg), int'(tbl[i].chg));
            chk("tbl_stable", 32'(stable), int'(tbl[i].stb));
            chk("tbl_pv", 32'(peak_valid), int'(tbl[i].pv));
            chk("tbl_peak", 32'(peak_out), tbl[i].peak);
        end
        cycle(1, 1, 1, 100);
        cycle(1, 1, 1, 100);
        cycle(1, 1, 1, CLIP);
        chk("clip_gain", 32'(gain_idx), 1);
        chk("clip_chg", 32'(gain_chg), 1);
        chk("clip_no_pv", 32'(peak_valid), 0);
        settle();
        cycle(1, 1, 1, CLIP);
        chk("clip_gain0", 32'(gain_idx), 0);
        settle();
        cycle(1, 1, 1, CLIP);
        chk("clip_limit_re", 32'(range_err), 1);
        chk("clip_limit_gain", 32'(gain_idx), 0);
        chk("clip_limit_chg", 32'(gain_chg), 0);
        win8(2500, 2500);
        chk("no_settle_pv", 32'(peak_valid), 1);
        chk("re_one_cycle", 32'(range_err), 0);
        for (int g = 1; g <= GMAX; g++) begin
            win8(1000, 1000);
            win8(1000, 1000);
            chk("step_up_gain", 32'(gain_idx), g);
            chk("step_up_chg", 32'(gain_chg), 1);
            settle();
        end
        win8(1000, 1000);
        win8(1000, 1000);
        chk("top_limit_re", 32'(range_err), 1);
        chk("top_limit_gain", 32'(gain_idx), 3);
        win8(3800, 100);
        win8(2500, 100);
        win8(3800, 100);
        chk("confirm_reset_gain", 32'(gain_idx), 3);
        chk("confirm_reset_chg", 32'(gain_chg), 0);
        win8(3800, 100);
        chk("over_step_gain", 32'(gain_idx), 2);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 1, 3000);
        chk("settle_rst_gain", 32'(gain_idx), 3);
        chk("settle_rst_stable", 32'(stable), 0);
        chk("settle_rst_peak", 32'(peak_out), 0);
        win8(2500, 2500);
        chk("rst_measure_pv", 32'(peak_valid), 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 2200);
        cycle(1, 0, 1, 2200);
        chk("dis_stable", 32'(stable), 0);
        chk("dis_pv", 32'(peak_valid), 0);
        for (int i = 0; i < 7; i++) cycle(1, 1, 1, 2200);
        chk("reen_no_pv", 32'(peak_valid), 0);
        cycle(1, 1, 1, 2200);
        chk("reen_pv", 32'(peak_valid), 1);
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) mode = $urandom_range(0, 3);
            r  = $urandom_range(0, 499) != 0;
            en = $urandom_range(0, 19) != 0;
            v  = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 39) == 0) d = CLIP;
            else if (mode == 0) d = $urandom_range(0, TH_L - 1);
            else if (mode == 1) d = $urandom_range(TH_L, TH_H - 1);
            else if (mode == 2) d = $urandom_range(TH_H, CLIP - 1);
            else d = $urandom_range(0, CLIP);
            cycle(r, en, v, d);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/agc_peak_ctrl.md
Name: agc_peak_ctrl

Overview:
- Parametrised successor of the relay auto-gain controller. Supports N gain steps, any ADC width, windowed peak detection, multi-window confirmation and fast clip attack.
- Sits after the ADC capture stage in the main clock domain. Drives the front-end relay/PGA gain index.
- Reports the window peak and a settled flag to downstream measurement logic.

Parameters:
DATA_W, 12, ADC sample width (unsigned magnitude).
NUM_GAINS, 4, number of gain steps. Index 0 = lowest gain, NUM_GAINS-1 = highest gain.
GAIN_W, 2, width of gain index. Must satisfy 2**GAIN_W >= NUM_GAINS.
RESET_GAIN, 3, gain index loaded at reset (highest gain).
WIN_LEN, 256, accepted samples per peak window (>=2).
SETTLE_CYC, 16, clk cycles ignored after any gain change (>=1).
CONFIRM, 2, consecutive qualifying windows needed before a step (>=1).
TH_HIGH, 3686, peak >= TH_HIGH qualifies the window as "over".
TH_LOW, 1792, peak < TH_LOW qualifies the window as "under". Must be < TH_HIGH; the gap between the two thresholds is the hysteresis.

Ports:
clk  in  1  main clock
rst_n  in  1  synchronous active-low reset
enable  in  1  controller run enable
sample_valid  in  1  sample_data is valid this cycle
sample_data  in  DATA_W  ADC magnitude sample
gain_idx  out  GAIN_W  current gain index to relay/PGA driver
gain_chg  out  1  one-cycle pulse on the cycle gain_idx changes
stable  out  1  gain settled and at least one full window measured since the last change
peak_out  out  DATA_W  peak of the last completed window
peak_valid  out  1  one-cycle pulse when peak_out updates
range_err  out  1  one-cycle pulse: step requested beyond index 0 or NUM_GAINS-1

Behaviour:
Reset and registers:
- Reset is synchronous, active-low, and sampled on posedge clk.
- Reset values: gain_idx=RESET_GAIN, gain_chg=0, stable=0, peak_out=0, peak_valid=0, range_err=0, state=MEASURE, all counters and the running peak = 0.
- Reset has priority over every other event, including mid-SETTLE.
- All outputs are registered.

States: MEASURE, SETTLE.

MEASURE:
- Each accepted sample (sample_valid=1) updates run_peak = max(run_peak, sample_data) and increments win_cnt.
- Window end: the accepted sample with win_cnt==WIN_LEN-1. On the next cycle:
  - peak_out = max(run_peak, that sample) and peak_valid=1.
  - run_peak and win_cnt clear.
  - stable=1 if no gain change occurred.
- Window classification:
  - over window: over_cnt+1 (saturating at CONFIRM), under_cnt=0.
  - under window: under_cnt+1, over_cnt=0.
  - in-band window: both counters clear.
- Step decision (same registered cycle as peak_valid):
  - over_cnt reaches CONFIRM: gain_idx-1.
  - under_cnt reaches CONFIRM: gain_idx+1.
- Clip (fast attack): an accepted sample equal to all-ones triggers a step down on the next cycle, with no window end or confirmation needed.
  - The partial window is discarded and peak_valid is not pulsed.
  - If the clip sample also ends a window, the clip path wins and peak_valid is suppressed.

Gain step:
- gain_idx updates, gain_chg=1 for one cycle, stable=0.
- over_cnt, under_cnt, run_peak and win_cnt all clear. State goes to SETTLE.

Limits:
- Step down requested at index 0, or step up at NUM_GAINS-1: gain_idx holds, range_err=1 for one cycle, counters clear, no SETTLE, state stays MEASURE.
- stable is unaffected by a limit event.

SETTLE:
- Lasts exactly SETTLE_CYC cycles counted from the gain_chg cycle. All samples are ignored, including clip samples.
- Then the state returns to MEASURE with a fresh window. stable stays 0 until the first full window completes.

enable:
- enable=0: gain_idx holds, stable=0, state forced to MEASURE, all counters and run_peak clear, no pulses.
- enable 0->1: measurement restarts from an empty window.

Test Plan:
- Bench overrides for all scenarios: WIN_LEN=8, SETTLE_CYC=4, CONFIRM=2.
1. Reset -> gain_idx=3, stable=0, peak_out=0, all pulses 0. Hold enable=1 and feed 8 valid samples of 2500 -> peak_valid with peak_out=2500, stable=1, gain_idx=3.
2. Two windows with peak 3800 (rest 100) -> first window: peak_valid, no change. Cycle after the 16th sample: gain_idx=2 and gain_chg=1; stable=0 for 4 cycles. Samples of 4000 during SETTLE are ignored (next peak_out excludes them).
3. Sample 4095 as the 3rd sample of a window at gain 2 -> next cycle gain_idx=1 and gain_chg=1, no peak_valid. Then force gain_idx=0 and send 4095 -> range_err=1 for one cycle, gain holds, no SETTLE.
4. Gain 3 with two windows of peak 1000 -> range_err pulse, gain_idx=3. Gain 1 with two windows of peak 1000 -> gain_idx=2.
5. Window sequence over(3800), in-band(2500), over(3800) -> no gain change (confirm counter reset). A further over window -> step down.
6. rst_n=0 two cycles into SETTLE -> next cycle all reset values, state MEASURE. Separately, enable=0 mid-window -> stable=0, no peak_valid; re-enable -> full fresh 8-sample window required before peak_valid.
